// File: rtl/fmul_rr_scheduler.sv
// Round-robin front end for one shared combinational FP32 multiplier: an operand
// register feeds the multiplier and a result register returns the ID-tagged product.
module fmul_rr_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*32-1:0]   req_a,
   input  logic [NUM_REQ*32-1:0]   req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [31:0]             mul_a,
   output logic [31:0]             mul_b,
   input  logic [31:0]             mul_y,
   output logic                    rsp_valid,
   output logic [31:0]             rsp_y,
   output logic [ID_W-1:0]         rsp_id,
   input  logic                    rsp_ready,
   output logic                    busy
);

   logic            op_valid;
   logic [31:0]     op_a;
   logic [31:0]     op_b;
   logic [ID_W-1:0] op_id;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] rr_ptr_next;

   logic            adv2;
   logic            accept;
   logic            found;
   logic            grant;
   logic [ID_W-1:0] winner;
   logic [ID_W:0]   idx;
   logic [31:0]     sel_a;
   logic [31:0]     sel_b;

   assign adv2   = op_valid & (~rsp_valid | rsp_ready);
   assign accept = ~op_valid | adv2;

   // Search from rr_ptr upward; idx is one bit wider so the wrap needs no modulo.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (!found && req_valid[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

   // Gating with rst_n keeps req_ready low for the whole reset window.
   assign grant     = rst_n & accept & found;
   assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

   assign rr_ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_id    <= '0;
         rr_ptr   <= '0;
      end else begin
         if (grant) begin
            op_valid <= 1'b1;
            op_a     <= sel_a;
            op_b     <= sel_b;
            op_id    <= winner;
            rr_ptr   <= rr_ptr_next;
         end else if (adv2) begin
            op_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_id    <= '0;
      end else begin
         if (adv2) begin
            rsp_valid <= 1'b1;
            rsp_y     <= mul_y;
            rsp_id    <= op_id;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign mul_a = op_a;
   assign mul_b = op_b;
   assign busy  = op_valid | rsp_valid;

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// Randomized bench for fmul_rr_scheduler: a transaction-level occupancy model predicts
// grants and rsp_valid; a scoreboard queue checks each returned product and tag in order.
module tb_fmul_rr_scheduler;
   localparam int unsigned N  = 4;
   localparam int unsigned IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic [31:0]     mul_a;
   logic [31:0]     mul_b;
   logic [31:0]     mul_y;
   logic            rsp_valid;
   logic [31:0]     rsp_y;
   logic [IW-1:0]   rsp_id;
   logic            rsp_ready;
   logic            busy;

   always #5 clk = ~clk;

   fmul_rr_scheduler #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_y     (mul_y),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   // FP32 multiply for normal operands, truncating; exact for the directed cases.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      int          e;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) return {a[31] ^ b[31], 8'(e + 1), m[46:24]};
      else       return {a[31] ^ b[31], 8'(e), m[45:23]};
   endfunction

   always_comb mul_y = fmul(mul_a, mul_b);

   function automatic logic [31:0] rand_op();
      return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
   endfunction

   int errors = 0;
   int checks = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   typedef struct packed {
      logic [31:0]   y;
      logic [IW-1:0] id;
   } rsp_t;

   rsp_t sb[$];

   // Model: pipeline occupancy (two slots) plus the next requester to search from.
   bit          m_s1, m_s2;
   int          m_ptr;
   logic [N-1:0] last_rdy;
   logic         last_rsp_valid;
   logic [31:0]  last_rsp_y;
   logic [IW-1:0] last_rsp_id;

   task automatic model_eval();
      bit           adv, acc, found;
      int           w;
      logic [N-1:0] exp_rdy;
      last_rdy       = req_ready;
      last_rsp_valid = rsp_valid;
      last_rsp_y     = rsp_y;
      last_rsp_id    = rsp_id;
      check("rsp_valid", rsp_valid, m_s2);
      check("busy", busy, m_s1 | m_s2);
      adv   = m_s1 && (!m_s2 || rsp_ready);
      acc   = !m_s1 || adv;
      found = 0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (!found && req_valid[c]) begin
            found = 1;
            w     = c;
         end
      end
      exp_rdy = (acc && found) ? N'(1) << w : '0;
      check("req_ready", req_ready, exp_rdy);
      if (acc && found) begin
         sb.push_back('{y: fmul(req_a[32*w +: 32], req_b[32*w +: 32]), id: IW'(w)});
         m_ptr = (w + 1) % N;
      end
      if (adv) m_s2 = 1;
      else if (rsp_ready) m_s2 = 0;
      if (acc && found) m_s1 = 1;
      else if (adv) m_s1 = 0;
   endtask

   task automatic step(input logic [N-1:0] v, input logic rr);
      req_valid = v;
      rsp_ready = rr;
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = rand_op();
         req_b[32*i +: 32] = rand_op();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_y"}, rsp_y, 0);
      check({tag, "_rsp_id"}, rsp_id, 0);
      check({tag, "_mul_a"}, mul_a, 0);
      check({tag, "_mul_b"}, mul_b, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Monitor: pops the scoreboard on every accepted response, checks hold under stall.
   bit            hold_prev = 0;
   logic [31:0]   prev_y;
   logic [IW-1:0] prev_id;
   rsp_t          mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 0;
      end else begin
         if (hold_prev) begin
            check("hold_y", rsp_y, prev_y);
            check("hold_id", rsp_id, prev_id);
            check("hold_valid", rsp_valid, 1);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_y", rsp_y, mon_e.y);
               check("rsp_id", rsp_id, mon_e.id);
            end
         end
         hold_prev = rsp_valid && !rsp_ready;
         prev_y    = rsp_y;
         prev_id   = rsp_id;
      end
   end

   initial begin
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      m_s1 = 0; m_s2 = 0; m_ptr = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("init");
      rst_n = 1'b1;

      // Round-robin with everyone requesting and no backpressure
      for (int i = 0; i < 12; i++) begin
         rand_ops();
         step('1, 1'b1);
         check("rr_grant", last_rdy, N'(1) << (i % N));
      end
      repeat (3) step('0, 1'b1);

      // Single transaction, 1.0 * 2.0 from requester 1
      req_a[63:32] = 32'h3F800000;
      req_b[63:32] = 32'h40000000;
      step(4'b0010, 1'b1);
      check("single_grant", last_rdy, 4'b0010);
      step('0, 1'b1);
      check("single_lat1", last_rsp_valid, 0);
      step('0, 1'b1);
      check("single_valid", last_rsp_valid, 1);
      check("single_y", last_rsp_y, 32'h40000000);
      check("single_id", last_rsp_id, 1);

      // Backpressure: 1.5 * 1.5 held while the consumer stalls
      req_a[31:0] = 32'h3FC00000;
      req_b[31:0] = 32'h3FC00000;
      step(4'b0001, 1'b0);
      check("bp_grant", last_rdy, 4'b0001);
      req_a[31:0] = rand_op();
      req_b[31:0] = rand_op();
      step(4'b0001, 1'b0);
      req_a[31:0] = rand_op();
      req_b[31:0] = rand_op();
      for (int i = 0; i < 5; i++) begin
         step(4'b0001, 1'b0);
         check("bp_ready_low", last_rdy, 0);
         check("bp_y", last_rsp_y, 32'h40100000);
      end
      step(4'b0001, 1'b1);
      repeat (4) step('0, 1'b1);

      // Wrap and skip: pointer parked at 3, only 0 and 2 requesting
      rand_ops();
      step(4'b0100, 1'b1);
      step(4'b0101, 1'b1);
      check("wrap_grant0", last_rdy, 4'b0001);
      step(4'b0101, 1'b1);
      check("wrap_grant2", last_rdy, 4'b0100);
      repeat (3) step('0, 1'b1);

      // Reset with both stages full
      rand_ops();
      repeat (3) step('1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      m_s1 = 0; m_s2 = 0; m_ptr = 0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step('1, 1'b1);
      check("post_rst_grant", last_rdy, 4'b0001);
      repeat (3) step('0, 1'b1);

      // Full-rate traffic with a toggling consumer, then fully random
      for (int i = 0; i < 300; i++) begin
         rand_ops();
         if (i < 150) step('1, 1'((i % 2) == 0));
         else         step(N'($urandom), 1'($urandom_range(1, 0)));
      end
      repeat (4) step('0, 1'b1);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
